// File: rtl/game_pkg.sv
// Shared types and constants for the rhythm-game chart pipeline.
// State encoding, lane count and the chart end sentinel live here.
package game_pkg;

   localparam int LANES         = 4;
   localparam int DEF_FALL_DIV  = 800000;
   localparam int DEF_ROW_TICKS = 140;

   localparam logic [LANES-1:0] CHART_END = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      PLAY,
      PAUSE,
      DONE
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV event counter: counts enabled cycles and pulses tc on the last one.
// Used both as the fall-tick prescaler and as the per-row tick counter.
module tick_prescaler #(
   parameter int DIV = 4,
   parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tc
);

   logic [W-1:0] count;

   // NOTE: tc is combinational so the pulse lands in the terminal-count cycle itself.
   assign tc = enable && (count == W'(DIV - 1));

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/chart_sequencer.sv
// Play-through sequencer for a 4-lane chart: start/pause/end FSM, fall-tick
// and row pacing, chart ROM addressing and spawn pulses.
module chart_sequencer
   import game_pkg::*;
#(
   parameter int FALL_DIV  = DEF_FALL_DIV,
   parameter int ROW_TICKS = DEF_ROW_TICKS,
   parameter int ADDR_W    = 11,
   parameter int CHART_LEN = 2048,
   parameter int ROM_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic [1:0]        sw,
   output logic [1:0]        rom_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [LANES-1:0]  rom_data,
   output logic              fall_tick,
   output logic              spawn_valid,
   output logic [LANES-1:0]  spawn_mask,
   output logic              playing,
   output logic              paused,
   output logic              done
);

   localparam int PW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

   state_e          state_q, state_d;
   logic [PW-1:0]   prime_cnt;
   logic            run, priming, row_end, is_end, last_addr, accept_start;

   assign run          = (state_q == PLAY);
   assign priming      = (state_q == PRIME);
   assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));
   assign is_end       = (rom_data == CHART_END);
   assign last_addr    = (rom_addr == ADDR_W'(CHART_LEN - 1));

   tick_prescaler #(.DIV(FALL_DIV), .W($clog2(FALL_DIV))) u_fall (
      .clk    (clk),
      .rst    (rst),
      .enable (run),
      .clear  (priming),
      .tc     (fall_tick)
   );

   // Row counter advances once per fall step; its terminal count is the row boundary.
   tick_prescaler #(.DIV(ROW_TICKS), .W($clog2(ROW_TICKS + 1))) u_row (
      .clk    (clk),
      .rst    (rst),
      .enable (fall_tick),
      .clear  (priming),
      .tc     (row_end)
   );

   assign spawn_valid = row_end && !is_end;
   assign spawn_mask  = spawn_valid ? rom_data : '0;

   // NOTE: next-state defaults to the current state first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = PRIME;
         PRIME:      if (prime_cnt == PW'(ROM_LAT)) state_d = PLAY;
         PLAY: begin
            if (row_end && (is_end || last_addr)) state_d = DONE;
            else if (pause)                       state_d = PAUSE;
         end
         PAUSE:      if (pause) state_d = PLAY;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         prime_cnt <= '0;
         rom_sel   <= '0;
         rom_addr  <= '0;
         playing   <= 1'b0;
         paused    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         playing   <= (state_d == PLAY);
         paused    <= (state_d == PAUSE);
         done      <= (state_d == DONE);
         prime_cnt <= priming ? prime_cnt + 1'b1 : '0;
         // The final row leaves the address parked rather than wrapping.
         if (accept_start) begin
            rom_sel  <= sw;
            rom_addr <= '0;
         end else if (spawn_valid && !last_addr) begin
            rom_addr <= rom_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer: directed play-through scenarios plus
// randomized start/pause/reset traffic, all checked against a cycle-count model.
module tb_chart_sequencer;

   localparam int FALL_DIV  = 4;
   localparam int ROW_TICKS = 3;
   localparam int ADDR_W    = 4;
   localparam int CHART_LEN = 8;
   localparam int ROM_LAT   = 1;

   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_PLAY  = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   logic              clk = 1'b0;
   logic              rst, start, pause;
   logic [1:0]        sw;
   logic [1:0]        rom_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        rom_data;
   logic              fall_tick, spawn_valid, playing, paused, done;
   logic [3:0]        spawn_mask;

   int tests = 0;
   int fails = 0;
   int cur   = 0;

   always #5 clk = ~clk;

   chart_sequencer #(
      .FALL_DIV  (FALL_DIV),
      .ROW_TICKS (ROW_TICKS),
      .ADDR_W    (ADDR_W),
      .CHART_LEN (CHART_LEN),
      .ROM_LAT   (ROM_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pause       (pause),
      .sw          (sw),
      .rom_sel     (rom_sel),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .fall_tick   (fall_tick),
      .spawn_valid (spawn_valid),
      .spawn_mask  (spawn_mask),
      .playing     (playing),
      .paused      (paused),
      .done        (done)
   );

   // Chart ROMs, one per song, with a single cycle of read latency.
   logic [3:0] rom_mem [4][16];
   always @(posedge clk) rom_data <= rom_mem[rom_sel][rom_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: time in PLAY is one elapsed-cycle count; ticks and row
   // boundaries follow from plain division of that count.
   int m_mode  = M_IDLE;
   int m_prime = 0;
   int m_cyc   = 0;
   int m_addr  = 0;
   int m_sel   = 0;
   bit m_valid = 1'b0;

   function automatic bit m_tick();
      return (m_mode == M_PLAY) && ((m_cyc % FALL_DIV) == FALL_DIV - 1);
   endfunction

   function automatic bit m_bound();
      return m_tick() && ((((m_cyc + 1) / FALL_DIV) % ROW_TICKS) == 0);
   endfunction

   function automatic bit m_spawn();
      return m_bound() && (rom_mem[m_sel][m_addr] != 4'hF);
   endfunction

   function automatic logic [3:0] m_mask();
      return m_spawn() ? rom_mem[m_sel][m_addr] : 4'h0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode  = M_IDLE;
         m_addr  = 0;
         m_sel   = 0;
         m_cyc   = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         case (m_mode)
            M_IDLE, M_DONE: if (start) begin
               m_sel   = int'(sw);
               m_addr  = 0;
               m_cyc   = 0;
               m_prime = ROM_LAT + 1;
               m_mode  = M_PRIME;
            end
            M_PRIME: begin
               m_prime--;
               if (m_prime == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
               bit b;
               b = m_bound();
               if (b) begin
                  if (rom_mem[m_sel][m_addr] == 4'hF) m_mode = M_DONE;
                  else if (m_addr == CHART_LEN - 1)  m_mode = M_DONE;
                  else                               m_addr++;
               end
               m_cyc++;
               if (m_mode == M_PLAY && pause) m_mode = M_PAUSE;
            end
            M_PAUSE: if (pause) m_mode = M_PLAY;
            default: m_mode = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cmp_playing",   playing,     m_mode == M_PLAY);
         check("cmp_paused",    paused,      m_mode == M_PAUSE);
         check("cmp_done",      done,        m_mode == M_DONE);
         check("cmp_rom_sel",   rom_sel,     m_sel);
         check("cmp_rom_addr",  rom_addr,    m_addr);
         check("cmp_fall_tick", fall_tick,   m_tick());
         check("cmp_spawn",     spawn_valid, m_spawn());
         check("cmp_mask",      spawn_mask,  m_mask());
      end
   end

   task automatic do_start(input logic [1:0] s);
      start = 1'b1;
      sw    = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      sw    = 2'($urandom_range(0, 3));
      cur   = 0;
   endtask

   task automatic at_cycle(input int k);
      repeat (k - cur) @(posedge clk);
      @(negedge clk);
      cur = k;
   endtask

   task automatic pulse_pause();
      pause = 1'b1;
      @(posedge clk);
      #1;
      pause = 1'b0;
      cur++;
   endtask

   task automatic count_ticks(input int from, input int upto, output int ticks);
      ticks = 0;
      for (int k = from; k <= upto; k++) begin
         at_cycle(k);
         if (fall_tick) ticks++;
      end
   endtask

   task automatic run_until_done(output int spawns, output bit got_done);
      spawns   = 0;
      got_done = 1'b0;
      for (int i = 0; i < 300 && !got_done; i++) begin
         @(negedge clk);
         if (spawn_valid) begin
            spawns++;
            check("s6_mask", spawn_mask, 4'h5);
         end
         if (done) got_done = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      bit  got;

      rst = 1'b1; start = 1'b0; pause = 1'b0; sw = 2'd0;
      for (int s = 0; s < 4; s++)
         for (int a = 0; a < 16; a++) rom_mem[s][a] = 4'hF;
      rom_mem[2][0] = 4'h1; rom_mem[2][1] = 4'h2; rom_mem[2][2] = 4'h4; rom_mem[2][3] = 4'h8;
      for (int a = 0; a < CHART_LEN; a++) begin
         rom_mem[1][a] = 4'h5;
         rom_mem[0][a] = 4'($urandom_range(0, 14));
         rom_mem[3][a] = 4'($urandom_range(0, 14));
      end
      rom_mem[3][5] = 4'hF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_playing",  playing,  0);
      check("rst_done",     done,     0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_rom_sel",  rom_sel,  0);
      rst = 1'b0;

      // Scenario 1/2: song 2 plays 1,2,4,8 then hits the sentinel.
      do_start(2'd2);
      at_cycle(0);  check("s1_rom_sel", rom_sel, 2); check("s1_play0", playing, 0);
      at_cycle(1);  check("s1_play1", playing, 0);
      at_cycle(2);  check("s1_play2", playing, 1);
      at_cycle(4);  check("s1_tick4", fall_tick, 0);
      at_cycle(5);  check("s1_tick5", fall_tick, 1); check("m_tick5", m_tick(), 1);
      at_cycle(9);  check("s1_tick9", fall_tick, 1);
      at_cycle(13); check("s1_spawn13", spawn_valid, 1); check("s1_mask13", spawn_mask, 1);
                    check("m_mask13", m_mask(), 1);
      at_cycle(14); check("s1_addr14", rom_addr, 1);
      at_cycle(25); check("s1_mask25", spawn_mask, 2);
      at_cycle(37); check("s1_mask37", spawn_mask, 4);
      at_cycle(49); check("s1_mask49", spawn_mask, 8);
      at_cycle(61); check("s2_tick61", fall_tick, 1); check("s2_nospawn61", spawn_valid, 0);
      at_cycle(62); check("s2_done62", done, 1); check("s2_play62", playing, 0);
                    check("m_done62", m_mode == M_DONE, 1);
      count_ticks(62, 82, n); check("s2_no_ticks", n, 0);

      // Scenario 3/4: pause freezes the prescaler, pause on a spawn cycle.
      do_start(2'd2);
      at_cycle(7);  pulse_pause();
      at_cycle(8);  check("s3_paused8", paused, 1);
      count_ticks(8, 27, n); check("s3_no_ticks", n, 0);
      pulse_pause();
      at_cycle(28); check("s3_play28", playing, 1); check("s3_tick28", fall_tick, 0);
      at_cycle(29); check("s3_tick29", fall_tick, 1);
      at_cycle(33); check("s4_spawn33", spawn_valid, 1); check("s4_mask33", spawn_mask, 1);
      pulse_pause();
      at_cycle(34); check("s4_paused34", paused, 1); check("s4_addr34", rom_addr, 1);
      at_cycle(35); pulse_pause();

      // Scenario 5: reset mid-PLAY at rom_addr 3.
      at_cycle(60); check("s5_addr60", rom_addr, 3); check("s5_play60", playing, 1);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; cur++;
      at_cycle(61);
      check("s5_rst_play",  playing,     0);
      check("s5_rst_addr",  rom_addr,    0);
      check("s5_rst_sel",   rom_sel,     0);
      check("s5_rst_tick",  fall_tick,   0);
      check("s5_rst_spawn", spawn_valid, 0);

      // Scenario 6: all-5 chart runs out at CHART_LEN, then replays from DONE.
      do_start(2'd1);
      at_cycle(0); check("s6_addr0", rom_addr, 0); check("s6_sel", rom_sel, 1);
      run_until_done(n, got);
      check("s6_done_seen", got, 1); check("s6_spawns", n, 8);
      do_start(2'd1);
      at_cycle(0); check("s6_prime", done, 0);
      run_until_done(n, got);
      check("s6_redone_seen", got, 1); check("s6_respawns", n, 8);

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         start = ($urandom_range(0, 39) == 0);
         pause = ($urandom_range(0, 24) == 0);
         sw    = 2'($urandom_range(0, 3));
         rst   = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk); #1;
      start = 1'b0; pause = 1'b0; rst = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
